tmul_mac_ctrl: RTL and testbench

TMUL_MAC_CTRL -- requirements
Module: tmul_mac_ctrl

---
 rtl/tmac_pkg.sv | 28 ++
 rtl/tmul_mac_ctrl_if.sv | 27 ++
 rtl/vdc_seq_gen.sv | 29 ++
 rtl/tmul_mac_ctrl.sv | 103 ++++++++++
 tb/tb_tmul_mac_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tmac_pkg.sv
// Shared types and helpers for the temporal-multiplier MAC controller.
package tmac_pkg;

   localparam int DW_DEF   = 8;
   localparam int ACCW_DEF = 16;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      ARM  = 3'd2,
      RUN  = 3'd3,
      OUT  = 3'd4
   } state_t;

   // Reverses the low w bits of v (w <= 32); upper result bits are zero.
   function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
      logic [31:0] src;
      logic [31:0] r;
      src = v;
      r   = '0;
      for (int i = 0; i < w; i++) begin
         r   = {r[30:0], src[0]};
         src = src >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/tmul_mac_ctrl_if.sv
// Operand-pair input stream and dot-product result stream of the MAC controller.
interface tmul_mac_ctrl_if
   import tmac_pkg::*;
#(
   parameter int DW   = DW_DEF,
   parameter int ACCW = ACCW_DEF
);
   logic            in_valid;
   logic            in_ready;
   logic [DW-1:0]   in_a;
   logic [DW-1:0]   in_b;
   logic            in_last;
   logic            out_valid;
   logic            out_ready;
   logic [ACCW-1:0] out_acc;

   modport master (
      output in_valid, in_a, in_b, in_last, out_ready,
      input  in_ready, out_valid, out_acc
   );

   modport slave (
      input  in_valid, in_a, in_b, in_last, out_ready,
      output in_ready, out_valid, out_acc
   );

endinterface

// File: rtl/vdc_seq_gen.sv
// Van der Corput comparison sequence: counter with clear/enable, output is the
// bit-reversed count (combinational from the register, zero after reset).
module vdc_seq_gen
   import tmac_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          enable,
   output logic [DW-1:0] seq
);

   logic [DW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign seq = DW'(bitrev(32'(cnt), DW));

endmodule

// File: rtl/tmul_mac_ctrl.sv
// Dot-product controller for a temporal multiplier: one pair in flight, A+3 cycles
// per pair; in_ready only in IDLE, result held on out_valid until out_ready.
module tmul_mac_ctrl
   import tmac_pkg::*;
#(
   parameter int DW   = DW_DEF,
   parameter int ACCW = ACCW_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   tmul_mac_ctrl_if.slave  bus,
   output logic            loadA,
   output logic            loadB,
   output logic [DW-1:0]   mulA,
   output logic [DW-1:0]   mulB,
   output logic [DW-1:0]   sobolSeq,
   input  logic            mul_oC,
   input  logic            mul_stop
);

   localparam logic [ACCW-1:0] ACC_MAX = '1;

   state_t          state;
   logic            op_last;
   logic [ACCW-1:0] acc;
   logic            seq_clear;
   logic            seq_en;

   assign seq_clear = (state == LOAD);
   assign seq_en    = (state == RUN) && !mul_stop;

   vdc_seq_gen #(.DW(DW)) u_vdc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (seq_clear),
      .enable (seq_en),
      .seq    (sobolSeq)
   );

   // mulA/mulB double as the operand registers: loaded on acceptance, held until the next pair.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         op_last       <= 1'b0;
         acc           <= '0;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.out_acc   <= '0;
         loadA         <= 1'b0;
         loadB         <= 1'b0;
         mulA          <= '0;
         mulB          <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && bus.in_ready) begin
                  mulA         <= bus.in_a;
                  mulB         <= bus.in_b;
                  op_last      <= bus.in_last;
                  loadA        <= 1'b1;
                  loadB        <= 1'b1;
                  bus.in_ready <= 1'b0;
                  state        <= LOAD;
               end
            end
            LOAD: begin
               loadA <= 1'b0;
               loadB <= 1'b0;
               state <= ARM;
            end
            ARM: begin
               state <= RUN;
            end
            RUN: begin
               if (mul_stop) begin
                  if (op_last) begin
                     bus.out_valid <= 1'b1;
                     bus.out_acc   <= acc;
                     state         <= OUT;
                  end else begin
                     bus.in_ready <= 1'b1;
                     state        <= IDLE;
                  end
               end else if (mul_oC && (acc != ACC_MAX)) begin
                  acc <= acc + 1'b1;
               end
            end
            OUT: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  acc           <= '0;
                  state         <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tmul_mac_ctrl.sv
// Two controllers (ACCW=16 and ACCW=8) share one stimulus stream, each with its own temporal multiplier.
// A driver pushes expected dot products into per-DUT queues; a monitor pops them on each result handshake.
module tb_tmul_mac_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   logic       in_valid;
   logic       in_last;
   logic       out_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   bit         hold_low;

   tmul_mac_ctrl_if #(.DW(8), .ACCW(16)) bus16 ();
   tmul_mac_ctrl_if #(.DW(8), .ACCW(8))  bus8 ();

   assign bus16.in_valid  = in_valid;
   assign bus16.in_a      = in_a;
   assign bus16.in_b      = in_b;
   assign bus16.in_last   = in_last;
   assign bus16.out_ready = out_ready;
   assign bus8.in_valid   = in_valid;
   assign bus8.in_a       = in_a;
   assign bus8.in_b       = in_b;
   assign bus8.in_last    = in_last;
   assign bus8.out_ready  = out_ready;

   wire [1:0]      ld_a;
   wire [1:0]      ld_b;
   wire [1:0][7:0] m_a;
   wire [1:0][7:0] m_b;
   wire [1:0][7:0] sob;
   wire [1:0]      m_oc;
   wire [1:0]      m_stop;

   tmul_mac_ctrl #(.DW(8), .ACCW(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .bus(bus16),
      .loadA(ld_a[0]), .loadB(ld_b[0]), .mulA(m_a[0]), .mulB(m_b[0]),
      .sobolSeq(sob[0]), .mul_oC(m_oc[0]), .mul_stop(m_stop[0])
   );

   tmul_mac_ctrl #(.DW(8), .ACCW(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .bus(bus8),
      .loadA(ld_a[1]), .loadB(ld_b[1]), .mulA(m_a[1]), .mulB(m_b[1]),
      .sobolSeq(sob[1]), .mul_oC(m_oc[1]), .mul_stop(m_stop[1])
   );

   // Temporal multiplier: A is armed one cycle after the load strobe, then counts down;
   // each active cycle emits B > sobolSeq, and stop flags an exhausted countdown.
   logic [1:0][7:0] mc_cnt;
   logic [1:0][7:0] mc_b;
   logic [1:0]      mc_ld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mc_cnt <= '0;
         mc_b   <= '0;
         mc_ld  <= '0;
      end else begin
         for (int d = 0; d < 2; d++) begin
            mc_ld[d] <= ld_a[d];
            if (ld_b[d]) mc_b[d] <= m_b[d];
            if (mc_ld[d]) mc_cnt[d] <= m_a[d];
            else if (mc_cnt[d] != 8'd0) mc_cnt[d] <= mc_cnt[d] - 8'd1;
         end
      end
   end

   assign m_oc   = {(mc_cnt[1] != 8'd0) && (sob[1] < mc_b[1]), (mc_cnt[0] != 8'd0) && (sob[0] < mc_b[0])};
   assign m_stop = {mc_cnt[1] == 8'd0, mc_cnt[0] == 8'd0};

   // Reference model: product of a pair is how many of the first A van der Corput points fall below B.
   function automatic int rev8(input int v);
      int r = 0;
      for (int k = 0; k < 8; k++) r = r * 2 + ((v >> k) & 1);
      return r;
   endfunction

   function automatic int pair_prod(input int a, input int b);
      int n = 0;
      for (int i = 0; i < a; i++) if (rev8(i) < b) n++;
      return n;
   endfunction

   int q16[$];
   int q8[$];
   int psum = 0;
   int exp_out_cyc = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_out_valid"}, {bus16.out_valid, bus8.out_valid}, 0);
      chk({tag, "_out_acc16"}, bus16.out_acc, 0);
      chk({tag, "_out_acc8"}, bus8.out_acc, 0);
      chk({tag, "_load"}, {ld_a, ld_b}, 0);
      chk({tag, "_mul_ops"}, {m_a, m_b}, 0);
      chk({tag, "_sobol"}, sob, 0);
      chk({tag, "_in_ready"}, {bus16.in_ready, bus8.in_ready}, 3);
   endtask

   // Issue one pair and follow it cycle by cycle; abort_at >= 0 stops following it at that cycle.
   task automatic send(input int a, input int b, input bit last, input int abort_at);
      int k = 0;
      while (!bus16.in_ready && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (!bus16.in_ready) begin
         chk("in_ready_wait", bus16.in_ready, 1);
         return;
      end
      if (abort_at < 0) begin
         psum += pair_prod(a, b);
         if (last) begin
            q16.push_back(psum > 65535 ? 65535 : psum);
            q8.push_back(psum > 255 ? 255 : psum);
            psum = 0;
         end
      end
      in_valid = 1'b1;
      in_a     = 8'(a);
      in_b     = 8'(b);
      in_last  = last;
      @(negedge clk);
      if (last) exp_out_cyc = cyc + a + 3;
      for (int k2 = 0; k2 <= a + 3; k2++) begin
         if (k2 > 0) @(negedge clk);
         if (k2 == abort_at) begin
            in_valid = 1'b0;
            return;
         end
         in_valid = (k2 < a + 2) ? 1'($urandom_range(0, 1)) : 1'b0;
         in_a     = 8'($urandom);
         in_b     = 8'($urandom);
         in_last  = 1'($urandom);
         chk("in_ready_busy", bus16.in_ready, (k2 == a + 3) && !last);
         if (k2 == 0) chk("load_strobes", {ld_a, ld_b}, 15);
         else         chk("load_low", {ld_a, ld_b}, 0);
         chk("mulA", m_a[0], a);
         chk("mulB", m_b[0], b);
         if (k2 >= 2 && k2 <= a + 1) begin
            chk("sobolSeq16", sob[0], rev8(k2 - 2));
            chk("sobolSeq8", sob[1], rev8(k2 - 2));
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while ((q16.size() != 0 || q8.size() != 0 || !bus16.in_ready) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("drain_pending", q16.size() + q8.size(), 0);
      chk("drain_in_ready", bus16.in_ready, 1);
   endtask

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: compares every presented result with the queue head and pops on handshake.
   bit seen[2];
   bit prev_hold[2];
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int d = 0; d < 2; d++) begin
            seen[d]      = 1'b0;
            prev_hold[d] = 1'b0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            logic ov;
            int   oa;
            int   qn;
            ov = (d == 0) ? bus16.out_valid : bus8.out_valid;
            oa = (d == 0) ? int'(bus16.out_acc) : int'(bus8.out_acc);
            qn = (d == 0) ? q16.size() : q8.size();
            if (prev_hold[d]) chk("out_valid_hold", ov, 1);
            if (ov) begin
               if (!seen[d]) begin
                  seen[d] = 1'b1;
                  chk("out_latency", cyc, exp_out_cyc);
               end
               if (qn == 0) begin
                  chk("unexpected_out_valid", ov, 0);
               end else begin
                  chk(d == 0 ? "out_acc16" : "out_acc8", oa, (d == 0) ? q16[0] : q8[0]);
                  if (out_ready) begin
                     if (d == 0) void'(q16.pop_front());
                     else        void'(q8.pop_front());
                     seen[d] = 1'b0;
                  end
               end
            end
            prev_hold[d] = ov && !out_ready;
         end
      end
   end

   initial begin
      int a;
      int b;
      bit last;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      in_last  = 1'b0;
      hold_low = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready_after_reset", {bus16.in_ready, bus8.in_ready}, 3);

      send(128, 128, 1'b1, -1);
      send(255, 255, 1'b1, -1);
      send(0, 200, 1'b1, -1);
      send(128, 128, 1'b0, -1);
      send(255, 255, 1'b1, -1);
      drain();

      // Saturating pair sum with the result held back for 10 cycles.
      hold_low = 1'b1;
      send(255, 255, 1'b0, -1);
      send(255, 255, 1'b1, -1);
      repeat (10) @(negedge clk);
      chk("held_out_valid", {bus16.out_valid, bus8.out_valid}, 3);
      chk("held_out_acc8", bus8.out_acc, 255);
      hold_low = 1'b0;
      drain();

      // Asynchronous reset in the middle of a run discards the partial sum.
      send(200, 200, 1'b1, 60);
      #2 rst_n = 1'b0;
      #1 chk_reset("mid_run_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(128, 128, 1'b1, -1);
      drain();

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 4))
            0:       a = 0;
            1:       a = 255;
            default: a = $urandom_range(1, 254);
         endcase
         case ($urandom_range(0, 4))
            0:       b = 0;
            1:       b = 255;
            default: b = $urandom_range(1, 254);
         endcase
         last = (i == 39) || ($urandom_range(0, 2) == 0);
         send(a, b, last, -1);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
